// File: rtl/ieeedrv_idcache.sv
// Directory-sector ID cache: on image mount, reads the drive's directory sector
// and latches the 16-bit disk ID from the streamed bytes, with host override.
module ieeedrv_idcache #(
    parameter int SUBDRV   = 2,
    parameter int DIR_LBA0 = 1102,
    parameter int DIR_LBA1 = 357,
    parameter int OFS_A    = 'h18,
    parameter int OFS_B    = 'hA2,
    parameter int TMO_W    = 16,
    localparam int SW      = (SUBDRV > 1) ? $clog2(SUBDRV) : 1
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   drv_type,
    input  logic [SUBDRV-1:0]      img_mounted,
    input  logic [2*SUBDRV-1:0]    img_type,
    output logic [31:0]            sd_lba,
    output logic [SUBDRV-1:0]      sd_rd,
    input  logic [SUBDRV-1:0]      sd_ack,
    input  logic [12:0]            sd_buff_addr,
    input  logic [7:0]             sd_buff_dout,
    input  logic                   sd_buff_wr,
    input  logic                   id_wr,
    input  logic [SW-1:0]          id_sel,
    input  logic [15:0]            id_hdr,
    output logic [16*SUBDRV-1:0]   dsk_id,
    output logic [SUBDRV-1:0]      id_loaded,
    output logic                   busy,
    output logic [SUBDRV-1:0]      tmo_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Timeout fires on the cycle the counter steps onto all-ones.
    localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);

    logic [1:0]        state;
    logic [SW-1:0]     sel;
    logic [SW-1:0]     ptr;
    logic [SW-1:0]     nxt;
    logic              found;
    logic [SUBDRV-1:0] pending;
    logic              stale;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              ack_sel;
    logic              mount_sel;
    logic [12:0]       ofs;

    always_comb begin
        found = 1'b0;
        nxt   = '0;
        for (int k = 0; k < SUBDRV; k++) begin
            if (!found && pending[(int'(ptr) + k) % SUBDRV]) begin
                found = 1'b1;
                nxt   = SW'((int'(ptr) + k) % SUBDRV);
            end
        end
    end

    always_comb begin
        ack_sel   = sd_ack[sel];
        mount_sel = img_mounted[sel];
        ofs       = img_type[2*int'(sel)+1] ? 13'(OFS_B) : 13'(OFS_A);
    end

    always_comb begin
        sd_rd  = '0;
        sd_lba = '0;
        if (state == S_REQ) begin
            sd_rd[sel] = 1'b1;
            sd_lba     = drv_type ? 32'(DIR_LBA1) : 32'(DIR_LBA0);
        end
        busy = (state != S_IDLE);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            sel       <= '0;
            ptr       <= '0;
            pending   <= '0;
            stale     <= 1'b0;
            tmo_cnt   <= '0;
            dsk_id    <= '0;
            id_loaded <= '0;
            tmo_err   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        sel          <= nxt;
                        ptr          <= (int'(nxt) == SUBDRV-1) ? '0 : SW'(int'(nxt) + 1);
                        pending[nxt] <= 1'b0;
                        // A mount landing on the very cycle we pick the drive also invalidates this read.
                        stale        <= img_mounted[nxt];
                        tmo_cnt      <= '0;
                        state        <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mount_sel) stale <= 1'b1;
                    if (ack_sel) begin
                        state <= S_XFER;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_cnt      <= tmo_cnt + 1'b1;
                        tmo_err[sel] <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_XFER: begin
                    if (mount_sel) stale <= 1'b1;
                    if (ack_sel && sd_buff_wr) begin
                        if (sd_buff_addr == ofs)
                            dsk_id[16*int'(sel) +: 8] <= sd_buff_dout;
                        if (sd_buff_addr == 13'(ofs + 13'd1))
                            dsk_id[16*int'(sel)+8 +: 8] <= sd_buff_dout;
                    end
                    if (!ack_sel) state <= S_DONE;
                end
                default: begin
                    if (!stale) id_loaded[sel] <= 1'b1;
                    state <= S_IDLE;
                end
            endcase

            // Host override beats capture; a mount beats everything for its drive.
            if (id_wr && (int'(id_sel) < SUBDRV)) begin
                dsk_id[16*int'(id_sel) +: 16] <= id_hdr;
                id_loaded[id_sel]             <= 1'b1;
            end

            for (int i = 0; i < SUBDRV; i++) begin
                if (img_mounted[i]) begin
                    pending[i]   <= 1'b1;
                    id_loaded[i] <= 1'b0;
                    tmo_err[i]   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/ieeedrv_idcache.md
IEEEDRV_IDCACHE -- requirements
Module: ieeedrv_idcache

Interface
REQ-001 SHALL have parameter SUBDRV, default 2, number of subdrives, legal 1..4.
REQ-002 SHALL have parameter DIR_LBA0, default 1102, directory sector LBA when drv_type=0.
REQ-003 SHALL have parameter DIR_LBA1, default 357, directory sector LBA when drv_type=1.
REQ-004 SHALL have parameter OFS_A, default 'h18, ID offset when img_type bit1=0.
REQ-005 SHALL have parameter OFS_B, default 'hA2, ID offset when img_type bit1=1.
REQ-006 SHALL have parameter TMO_W, default 16, timeout counter width.
REQ-007 SHALL use one clock; reset is asynchronous and active-low.
REQ-008 clk_sys  in  1  system clock, all state on rising edge.
REQ-009 reset_n  in  1  asynchronous active-low reset.
REQ-010 drv_type  in  1  selects DIR_LBA1 (1) or DIR_LBA0 (0).
REQ-011 img_mounted  in  SUBDRV  per-subdrive mount pulse.
REQ-012 img_type  in  2*SUBDRV  per-subdrive image type, bits [2i+1:2i].
REQ-013 sd_lba  out  32  sector requested.
REQ-014 sd_rd  out  SUBDRV  read request, one-hot or zero.
REQ-015 sd_ack  in  SUBDRV  SD transfer acknowledge.
REQ-016 sd_buff_addr  in  13  byte address of current transfer.
REQ-017 sd_buff_dout  in  8  transfer data.
REQ-018 sd_buff_wr  in  1  transfer data strobe.
REQ-019 id_wr  in  1  header ID override strobe.
REQ-020 id_sel  in  max(1,clog2(SUBDRV))  subdrive targeted by id_wr.
REQ-021 id_hdr  in  16  override ID value.
REQ-022 dsk_id  out  16*SUBDRV  cached ID per subdrive, bits [16i+15:16i].
REQ-023 id_loaded  out  SUBDRV  ID valid per subdrive.
REQ-024 busy  out  1  high in any state other than IDLE.
REQ-025 tmo_err  out  SUBDRV  sticky timeout flag per subdrive.

Function
REQ-026 SHALL set pending[i], clear id_loaded[i] and tmo_err[i] on img_mounted[i]=1.
REQ-027 SHALL run FSM IDLE->REQ->XFER->DONE->IDLE.
REQ-028 IDLE: when any pending, SHALL select next pending index round-robin starting after last served (after reset start at 0), clear its pending, clear stale, enter REQ next cycle.
REQ-029 REQ: SHALL drive sd_rd[sel]=1, sd_lba=DIR_LBA per drv_type (zero-extended), count cycles; on sd_ack[sel]=1 go XFER.
REQ-030 REQ timeout: counter reaching all-ones SHALL drop sd_rd, set tmo_err[sel], go IDLE without setting id_loaded.
REQ-031 XFER: sd_rd SHALL drop to 0 first cycle of XFER; while sd_ack[sel]=1 and sd_buff_wr=1, addr==OFS SHALL latch dsk_id[sel][7:0], addr==OFS+1 SHALL latch [15:8], OFS from img_type[sel] bit1.
REQ-032 XFER SHALL go DONE on sd_ack[sel] falling (1->0).
REQ-033 DONE SHALL set id_loaded[sel]=1 unless stale, one cycle, then IDLE.
REQ-034 img_mounted[sel] during REQ/XFER SHALL set stale and pending[sel]; transfer completes, id_loaded stays 0, drive re-served later.
REQ-035 id_wr SHALL load dsk_id[id_sel]=id_hdr, set id_loaded[id_sel]=1, any state, same cycle as strobe (visible next cycle).
REQ-036 id_wr coinciding with capture write to same byte SHALL win; coinciding with img_mounted to same drive, mount wins (id_loaded=0).
REQ-037 sd_ack of non-selected subdrives and sd_buff_wr outside XFER SHALL be ignored.
REQ-038 id_sel >= SUBDRV SHALL be ignored.
REQ-039 sd_lba SHALL be 0 when sd_rd is 0.

Reset
REQ-040 reset_n=0 SHALL asynchronously force IDLE, sd_rd=0, sd_lba=0, busy=0, dsk_id=0, id_loaded=0, tmo_err=0, pending=0, stale=0, timeout counter=0, round-robin pointer=0.
REQ-041 Deassertion mid-transfer SHALL leave block IDLE with no pending; external ack ignored until next mount.

Verification
REQ-042 drv_type=0, mount drive 0 type 0, ack after 5 cycles, write 256 bytes with bytes 'h18='h41,'h19='h42 -> sd_lba=1102, dsk_id[0]='h4241, id_loaded[0]=1 one cycle after DONE.
REQ-043 Mount drives 0 and 1 same cycle, img_type[1]=2, drv_type=1 -> drive 0 served first, then drive 1 at LBA 357 capturing 'hA2/'hA3.
REQ-044 Mount drive 1, never ack, TMO_W=4 -> sd_rd drops after 15 cycles in REQ, tmo_err[1]=1, id_loaded[1]=0, busy=0.
REQ-045 Remount drive 0 during XFER -> id_loaded[0]=0 after DONE, second REQ issued, loaded after second transfer.
REQ-046 id_wr id_sel=1 id_hdr='hBEEF during drive 1 XFER write to 'h18 -> dsk_id[1]='hBEEF.
REQ-047 reset_n low mid-XFER -> all outputs zero asynchronously, no request after release.
